alu_rr_scheduler: RTL and testbench

- Shares one ALU instance between NUM_REQ requesters, e.g. integer pipe, address-gen unit and CSR/test port.
- Arbitrates round-robin, issues at most one operation per cycle into the ALU, and tracks in-flight operations through the ALU latency.
- Returns each result on a common response bus, tagged with the requester id.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/alu_rr_scheduler.sv | 116 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and bus payload types for the ALU round-robin scheduler.
package alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_ID_W = 3;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic F7_ALT = 1'b1;

  typedef struct packed {
    logic [2:0]        funct3;
    logic              funct7;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } alu_op_t;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } alu_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted index.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last;

  // Pointer parks on N-1 so requester 0 wins first after reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      last <= IDX_W'(N - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters: round-robin issue, registered ALU
// inputs and a tag pipeline that returns each result with its owner's id.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*3-1:0]            req_funct3,
  input  logic [NUM_REQ-1:0]              req_funct7,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
  output logic [2:0]                      alu_funct3,
  output logic                            alu_funct7,
  output logic [DATA_WIDTH-1:0]           alu_opa,
  output logic [DATA_WIDTH-1:0]           alu_opb,
  input  logic [DATA_WIDTH-1:0]           alu_res,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            idle
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  alu_op_t            op_sel;
  alu_op_t            op_q;
  alu_tag_t           tag_q [0:ALU_LATENCY];
  logic               any_inflight;

  // Requests are masked while disabled or in reset so no grant can appear
  assign arb_req = (en && !rstn) ? req_valid : '0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (arb_req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Operand mux driven by the one-hot grant
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_sel.funct3 = req_funct3[3*i +: 3];
        op_sel.funct7 = req_funct7[i];
        op_sel.opa    = DATA_W'(req_opa[DATA_WIDTH*i +: DATA_WIDTH]);
        op_sel.opb    = DATA_W'(req_opb[DATA_WIDTH*i +: DATA_WIDTH]);
      end
    end
  end

  // ALU input registers hold their value between accepts
  always_ff @(posedge clk) begin
    if (rstn) begin
      op_q <= '0;
    end else if (accept) begin
      op_q <= op_sel;
    end
  end

  assign alu_funct3 = op_q.funct3;
  assign alu_funct7 = op_q.funct7;
  assign alu_opa    = DATA_WIDTH'(op_q.opa);
  assign alu_opb    = DATA_WIDTH'(op_q.opb);

  // Tag pipeline: stage 0 marks the issue, ALU_LATENCY more stages track the ALU
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned s = 0; s <= ALU_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: accept, id: TAG_ID_W'(grant_idx)};
      for (int unsigned s = 1; s <= ALU_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign rsp_valid = tag_q[ALU_LATENCY].valid;
  assign rsp_id    = tag_q[ALU_LATENCY].id[ID_W-1:0];
  assign rsp_data  = alu_res;

  if (ID_W < TAG_ID_W) begin : g_id_pad
    logic unused_id_bits;
    assign unused_id_bits = |tag_q[ALU_LATENCY].id[TAG_ID_W-1:ID_W];
  end

  always_comb begin
    any_inflight = 1'b0;
    for (int unsigned s = 0; s <= ALU_LATENCY; s++) begin
      any_inflight = any_inflight | tag_q[s].valid;
    end
    idle = ~any_inflight & ~accept;
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler with a 1-cycle registered ALU model.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_funct3;
  logic [1:0]  req_funct7;
  logic [63:0] req_opa;
  logic [63:0] req_opb;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_opa;
  logic [31:0] alu_opb;
  logic [31:0] alu_res;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        idle;

  logic        bv  [2];
  logic [2:0]  bf3 [2];
  logic        bf7 [2];
  logic [31:0] ba  [2];
  logic [31:0] bb  [2];

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   model_last;
  logic mon_en  = 1'b0;

  assign req_valid  = {bv[1], bv[0]};
  assign req_funct3 = {bf3[1], bf3[0]};
  assign req_funct7 = {bf7[1], bf7[0]};
  assign req_opa    = {ba[1], ba[0]};
  assign req_opb    = {bb[1], bb[0]};

  alu_rr_scheduler #(
    .DATA_WIDTH  (32),
    .NUM_REQ     (2),
    .ALU_LATENCY (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .alu_funct3 (alu_funct3),
    .alu_funct7 (alu_funct7),
    .alu_opa    (alu_opa),
    .alu_opb    (alu_opb),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_ADD:  return f7 ? a - b : a + b;
      F3_SLL:  return a << b[4:0];
      F3_SLT:  return {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: return {31'b0, a < b};
      F3_XOR:  return a ^ b;
      F3_SR:   return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction

  // External ALU with one register stage
  always @(posedge clk) alu_res <= alu_ref(alu_funct3, alu_funct7, alu_opa, alu_opb);

  // Response monitor: every pulse must match the queue head, on its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_tests++;
        n_fail++;
        e = sb.pop_front();
        $display("FAIL rsp_missing id=%0d data=%h due=%0d now=%0d", e.id, e.data, e.due, cyc);
      end
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected id=%0d data=%h cycle=%0d", rsp_id, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rsp_match got id=%0d data=%h cyc=%0d exp id=%0d data=%h cyc=%0d",
                     rsp_id, rsp_data, cyc, e.id, e.data, e.due);
          end
        end
      end else if (rsp_valid !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_valid_x got=%b exp=0/1", rsp_valid);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input int id, input logic [31:0] data);
    exp_t e;
    e.id   = 1'(id);
    e.data = data;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic v, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b);
    bv[i]  = v;
    bf3[i] = f3;
    bf7[i] = f7;
    ba[i]  = a;
    bb[i]  = b;
  endtask

  task automatic test_reset();
    tick();
    bv[0] = 1'b1;
    bv[1] = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    n_tests++;
    if ({alu_funct3, alu_funct7, alu_opa, alu_opb} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_alu got f3=%0d f7=%0d a=%h b=%h exp all zero",
               alu_funct3, alu_funct7, alu_opa, alu_opb);
    end
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp got valid=%b id=%b exp 0/0", rsp_valid, rsp_id);
    end
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=1", idle);
    end
    tick();
    bv[0] = 1'b0;
    bv[1] = 1'b0;
    rstn  = 1'b0;
    mon_en = 1'b1;
    model_last = 1;
  endtask

  task automatic test_simultaneous();
    tick();
    set_op(0, 1'b1, F3_ADD, F7_ALT, 32'd15, 32'd3);
    set_op(1, 1'b1, F3_AND, 1'b0, 32'hFF00FF00, 32'h00FF00FF);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_grant0 got=%b exp=01", req_ready);
    end
    push_exp(0, 32'd12);
    tick();
    bv[0] = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_grant1 got=%b exp=10", req_ready);
    end
    push_exp(1, 32'h00000000);
    tick();
    bv[1] = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL simul_nogrant got=%b exp=00", req_ready);
    end
    model_last = 1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    tick();
    set_op(0, 1'b1, F3_ADD, 1'b0, 32'd10, 32'd5);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_grant got=%b exp=01", req_ready);
    end
    push_exp(0, 32'd15);
    tick();
    bv[0] = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL single_nogrant got=%b exp=00", req_ready);
    end
    model_last = 0;
    repeat (4) tick();
  endtask

  task automatic test_fairness();
    for (int k = 0; k < 6; k++) begin
      int g;
      tick();
      for (int i = 0; i < 2; i++) begin
        logic [2:0] f3;
        f3 = 3'($urandom_range(0, 7));
        set_op(i, 1'b1, f3, (f3 == F3_ADD || f3 == F3_SR) ? 1'($urandom_range(0, 1)) : 1'b0,
               $urandom, $urandom);
      end
      g = (model_last + 1) % 2;
      #1;
      n_tests++;
      if (req_ready !== 2'(1 << g)) begin
        n_fail++;
        $display("FAIL fair_grant step=%0d got=%b exp=%b", k, req_ready, 2'(1 << g));
      end
      push_exp(g, alu_ref(bf3[g], bf7[g], ba[g], bb[g]));
      model_last = g;
    end
    tick();
    bv[0] = 1'b0;
    bv[1] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    tick();
    set_op(1, 1'b1, F3_SR, F7_ALT, 32'hFFFFFFF0, 32'd2);
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_sra got=%b exp=10", req_ready);
    end
    push_exp(1, 32'hFFFFFFFC);
    tick();
    set_op(1, 1'b1, F3_SLTU, 1'b0, 32'd10, 32'd20);
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_sltu got=%b exp=10", req_ready);
    end
    push_exp(1, 32'd1);
    tick();
    bv[1] = 1'b0;
    model_last = 1;
    repeat (3) tick();
  endtask

  task automatic test_drain();
    tick();
    set_op(0, 1'b1, F3_ADD, 1'b0, 32'd1, 32'd2);
    set_op(1, 1'b1, F3_ADD, 1'b0, 32'd100, 32'd200);
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_grant0 got=%b exp=01", req_ready);
    end
    push_exp(0, 32'd3);
    tick();
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_grant1 got=%b exp=10", req_ready);
    end
    push_exp(1, 32'd300);
    for (int k = 0; k < 4; k++) begin
      logic exp_idle;
      tick();
      en = 1'b0;
      exp_idle = (k >= 2);
      #1;
      n_tests++;
      if (req_ready !== 2'b00 || idle !== exp_idle) begin
        n_fail++;
        $display("FAIL drain_step%0d got ready=%b idle=%b exp ready=00 idle=%b",
                 k, req_ready, idle, exp_idle);
      end
    end
    tick();
    bv[0] = 1'b0;
    bv[1] = 1'b0;
    en = 1'b1;
    model_last = 1;
    repeat (2) tick();
  endtask

  task automatic test_reset_midflight();
    tick();
    set_op(1, 1'b1, F3_ADD, 1'b0, 32'd7, 32'd8);
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_grant1 got=%b exp=10", req_ready);
    end
    push_exp(1, 32'd15);
    tick();
    set_op(0, 1'b1, F3_ADD, 1'b0, 32'd1, 32'd1);
    bv[1] = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_grant0 got=%b exp=01", req_ready);
    end
    tick();
    rstn  = 1'b1;
    bv[1] = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_ready_in_reset got=%b exp=00", req_ready);
    end
    tick();
    rstn = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale_rsp got=%b exp=0", rsp_valid);
    end
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_ptr got=%b exp=01", req_ready);
    end
    push_exp(0, 32'd2);
    tick();
    bv[0] = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_next got=%b exp=10", req_ready);
    end
    push_exp(1, 32'd15);
    tick();
    bv[1] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rstn = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 2; i++) set_op(i, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_simultaneous();
    test_single();
    test_fairness();
    test_back_to_back();
    test_drain();
    test_reset_midflight();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty got=%0d pending exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
